alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 16-bit registered ALU.
- Accepts one 16-bit instruction per cycle and decodes its opcode into the ALU's 3-bit control code.
- Reads two source registers from an internal 8x16 register file, with bypass of the same-cycle writeback.
- Presents registered A, B and CTRL to the ALU.
- A per-register pending scoreboard stalls issue until an in-flight destination has been written back.

Parameters:
- DATA_W, 16, operand/register width; must equal ALU width.
- NREG, 8, register count; the register address is 3 bits, fixed by the instruction format.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- instr_valid  input  1  instr holds an instruction this cycle.
- instr  input  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored.
- instr_ready  output  1  combinational; 1 when no scoreboard hazard.
- flush  input  1  cancels the instruction presented this cycle.
- wb_en  input  1  writeback strobe from the downstream stage.
- wb_addr  input  3  writeback register.
- wb_data  input  16  writeback value.
- alu_a  output  16  registered operand A (rs value).
- alu_b  output  16  registered operand B (rt value).
- alu_ctrl  output  3  registered ALU control; 0 = bubble.
- ex_valid  output  1  registered; alu_a/alu_b/alu_ctrl carry a real instruction.
- ex_rd  output  3  registered destination tag, travels with the instruction.

Behaviour:
- Reset (sync, at posedge):
  - All 8 registers cleared to 0 and all pending bits cleared.
  - alu_a, alu_b, alu_ctrl, ex_rd set to 0; ex_valid set to 0.
  - Reset overrides wb_en, flush and issue in the same cycle. Mid-operation reset discards in-flight tags.
- Opcode mapping is identity: op 1 ADD, 2 XOR, 3 AND, 4 OR, 5 NOTA, 6 NAND, 7 NOR, 0 NOP.
- Register file:
  - r0 reads 0 always; writes to r0 are ignored.
  - Write at posedge when wb_en=1 and wb_addr!=0.
- Bypass: if wb_en=1 and wb_addr==rs (rs!=0) in the same cycle, operand A uses wb_data. Same rule for rt/B.
- Hazard (combinational):
  - A source rs or rt (nonzero) is hazardous when pending[src]=1, unless wb_en=1 and wb_addr==src this cycle.
  - instr_ready = !hazard. The signal is independent of instr_valid and flush.
- Issue (accept) condition: instr_valid & instr_ready & !flush. At the next posedge:
  - alu_a and alu_b capture the (bypassed) source values.
  - alu_ctrl <= op; ex_rd <= rd; ex_valid <= 1.
- NOP (op=0): issues normally with alu_ctrl=0 and ex_valid=1, and does not set pending.
- No issue (invalid, hazard or flush):
  - alu_ctrl <= 0, ex_valid <= 0, ex_rd <= 0.
  - alu_a and alu_b hold their previous values.
  - The upstream producer must hold instr while instr_ready=0.
- Scoreboard update per posedge:
  - Clear pending[wb_addr] if wb_en=1.
  - Then set pending[rd] if issue, op!=0 and rd!=0. Set wins over clear on the same register.
- Latency: instruction accepted at edge N appears at the ALU inputs after edge N and produces the ALU result after edge N+1. Writeback timing belongs to the downstream stage; this block only requires wb_en eventually.
- Arithmetic: no arithmetic here; pure selection, 16-bit paths, no width extension.
- Flush with a hazard present: no issue and no pending change, apart from a concurrent writeback clear.

Decomposition:
- Shared package (alu_pkg):
  - Opcode constants OP_NOP..OP_NOR (3'h0..3'h7), also used by the ALU.
  - Instruction field bit positions and DATA_W.
  - Register-address width.
- Natural sub-module: alu_regfile. It holds 8x16 storage with 2 combinational read ports, 1 sync write port, r0 forced to zero and the write-first bypass. The scoreboard and pipeline register stay in the top.

Test Plan:
- Reset, then wb r1=0x00F0 and r2=0x0F0F, then issue ADD r3,r1,r2 -> next cycle alu_a=0x00F0, alu_b=0x0F0F, alu_ctrl=1, ex_valid=1, ex_rd=3, pending[3]=1.
- Issue XOR r4,r3,r1 while pending[3]=1 -> instr_ready=0 and a bubble (ctrl=0, ex_valid=0) each cycle. Apply wb r3=0x0FFF -> same cycle instr_ready=1, next cycle alu_a=0x0FFF (bypass), alu_ctrl=2.
- Same cycle: wb_en r5=0xABCD and issue OR r5,r0,r5 -> alu_a=0, alu_b=0xABCD, and pending[5]=1 (set beats clear).
- Write r0=0xFFFF, then issue AND r6,r0,r0 -> alu_a=alu_b=0, pending[6]=1, pending[0] never set.
- Valid ADD with flush=1 -> ex_valid=0, alu_ctrl=0, pending unchanged. Then NOTA r7,r1 without flush -> alu_ctrl=5, pending[7]=1.
- Assert reset with pending[3]=1 and ex_valid=1 -> after the edge all outputs are 0, instr_ready=1, and r1 reads 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the operand stage and the ALU it feeds.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
    localparam int OP_W   = 3;

    // ALU control codes; the instruction opcode maps onto them one-to-one.
    localparam logic [OP_W-1:0] OP_NOP  = 3'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'h1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'h2;
    localparam logic [OP_W-1:0] OP_AND  = 3'h3;
    localparam logic [OP_W-1:0] OP_OR   = 3'h4;
    localparam logic [OP_W-1:0] OP_NOTA = 3'h5;
    localparam logic [OP_W-1:0] OP_NAND = 3'h6;
    localparam logic [OP_W-1:0] OP_NOR  = 3'h7;

    // Instruction field positions: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt.
    localparam int OP_LSB = 13;
    localparam int RD_LSB = 10;
    localparam int RS_LSB = 7;
    localparam int RT_LSB = 4;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: r0 hardwired to zero, two async read ports, one write port,
// read ports see a same-cycle write (write-first bypass).
// Latency: reads combinational, write visible in storage after the posedge.
// Backpressure: none; a write is always accepted.
// Ports: clk/reset (sync, active-high), we/waddr/wdata write port,
//        raddr_a/rdata_a and raddr_b/rdata_b read ports.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int NREG_P   = NREG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [REG_AW-1:0]   waddr,
    input  logic [DATA_W_P-1:0] wdata,
    input  logic [REG_AW-1:0]   raddr_a,
    output logic [DATA_W_P-1:0] rdata_a,
    input  logic [REG_AW-1:0]   raddr_b,
    output logic [DATA_W_P-1:0] rdata_b
);

    logic [NREG_P-1:0][DATA_W_P-1:0] mem_q;
    logic [NREG_P-1:0][DATA_W_P-1:0] mem_d;

    // Writes to r0 are dropped so entry 0 stays zero forever.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_a = mem_q[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mem_q[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the registered 16-bit ALU.
// Latency: instruction accepted at edge N drives alu_a/alu_b/alu_ctrl after edge N.
// Backpressure: instr_ready drops while a source register awaits writeback.
// Ports: clk/reset (sync, active-high); instr_valid/instr/instr_ready/flush upstream;
//        wb_en/wb_addr/wb_data writeback; alu_a/alu_b/alu_ctrl/ex_valid/ex_rd to ALU.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int NREG_P   = NREG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                instr_ready,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [DATA_W_P-1:0] wb_data,
    output logic [DATA_W_P-1:0] alu_a,
    output logic [DATA_W_P-1:0] alu_b,
    output logic [OP_W-1:0]     alu_ctrl,
    output logic                ex_valid,
    output logic [REG_AW-1:0]   ex_rd
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              instr_unused;

    assign op           = instr[OP_LSB +: OP_W];
    assign rd           = instr[RD_LSB +: REG_AW];
    assign rs           = instr[RS_LSB +: REG_AW];
    assign rt           = instr[RT_LSB +: REG_AW];
    assign instr_unused = ^instr[3:0];

    logic [DATA_W_P-1:0] rs_val;
    logic [DATA_W_P-1:0] rt_val;

    alu_regfile #(
        .DATA_W_P (DATA_W_P),
        .NREG_P   (NREG_P)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rs_val),
        .raddr_b (rt),
        .rdata_b (rt_val)
    );

    logic [NREG_P-1:0]   pending_q, pending_d;
    logic [DATA_W_P-1:0] alu_a_q, alu_a_d;
    logic [DATA_W_P-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_ctrl_q, alu_ctrl_d;
    logic                ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;

    logic rs_hazard;
    logic rt_hazard;
    logic issue;

    // A pending source is released in the very cycle its writeback arrives,
    // because the register file bypass supplies the value on the read port.
    always_comb begin
        rs_hazard = (rs != '0) && pending_q[rs] && !(wb_en && (wb_addr == rs));
        rt_hazard = (rt != '0) && pending_q[rt] && !(wb_en && (wb_addr == rt));
    end

    assign instr_ready = !(rs_hazard || rt_hazard);
    assign issue       = instr_valid && instr_ready && !flush;

    // Clear on writeback first, then set on issue, so a new producer of the
    // register being written back keeps its pending bit.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (issue && (op != OP_NOP) && (rd != '0)) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Operands hold across bubbles; only the control/tag fields go to zero.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = OP_NOP;
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        if (issue) begin
            alu_a_d    = rs_val;
            alu_b_d    = rt_val;
            alu_ctrl_d = op;
            ex_valid_d = 1'b1;
            ex_rd_d    = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= OP_NOP;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ctrl = alu_ctrl_q;
    assign ex_valid = ex_valid_q;
    assign ex_rd    = ex_rd_q;

endmodule
